rr_arbiter_8: RTL

//   Round-robin arbiter that shares one resource among 8 requesters.
//   - Arbitrates on a 3-bit winner index.
//   - Expands the index to a one-hot grant through a 3->8 decoder.
//   - Sits between the 8 requesting blocks and the shared resource; the resource mux selects on gnt_idx.

---
 rtl/rr_arb_pkg.sv | 29 ++
 rtl/onehot_dec_3to8.sv | 17 +
 rtl/rr_arbiter_8.sv | 132 +++++++++++++
 3 files changed

// File: rtl/rr_arb_pkg.sv
// Shared types and helpers for the 8-way round-robin arbiter.
// Pure declarations: no logic, no latency.
// No flow control; consumed by rr_arbiter_8 and its decoder.
package rr_arb_pkg;

    localparam int N_REQ = 8;
    localparam int IDX_W = 3;

    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } arb_state_t;

    // First set request at or above ptr, wrapping N_REQ-1 -> 0.
    // Returns {found, idx}; idx is meaningless when found is 0.
    function automatic logic [IDX_W:0] rr_pick(input logic [N_REQ-1:0] req,
                                               input logic [IDX_W-1:0] ptr);
        logic [IDX_W-1:0] idx;
        rr_pick = '0;
        // Walk from the farthest offset down so the nearest hit is kept last.
        for (int i = N_REQ - 1; i >= 0; i--) begin
            idx = ptr + IDX_W'(i);
            if (req[idx]) begin
                rr_pick = {1'b1, idx};
            end
        end
    endfunction

endpackage

// File: rtl/onehot_dec_3to8.sv
// Binary holder index to one-hot grant vector.
// Purely combinational, zero latency.
// No flow control; feeds the D input of the grant register.
module onehot_dec_3to8
    import rr_arb_pkg::*;
(
    input  logic [IDX_W-1:0] idx,
    output logic [N_REQ-1:0] onehot
);

    // Exactly one bit set for every index value.
    always_comb begin
        onehot      = '0;
        onehot[idx] = 1'b1;
    end

endmodule

// File: rtl/rr_arbiter_8.sv
// Round-robin arbiter, 8 requesters, no preemption; optional hold watchdog (ARB_TIMEOUT_EN).
// Latency: 1 cycle req -> gnt; holder hand-off happens in one edge with no idle bubble.
// Backpressure: holder keeps gnt while its req stays high; others wait (bounded by watchdog when built).
module rr_arbiter_8
    import rr_arb_pkg::*;
#(
`ifdef ARB_TIMEOUT_EN
    parameter int TIMEOUT_CYCLES = 16,
    parameter int CNT_W          = 5
`endif
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [N_REQ-1:0] req,
    output logic [N_REQ-1:0] gnt,
    output logic [IDX_W-1:0] gnt_idx,
    output logic             gnt_valid,
    output logic             timeout
);

    arb_state_t       state;
    arb_state_t       state_nxt;
    logic [IDX_W-1:0] rr_ptr;
    logic [IDX_W-1:0] ptr_nxt;
    logic [IDX_W-1:0] idx_nxt;
    logic             vld_nxt;
    logic [IDX_W-1:0] scan_ptr;
    logic [IDX_W:0]   pick;
    logic             holder_req;
    logic             release_now;
    logic             revoke;
    logic             new_grant;
    logic [N_REQ-1:0] dec_onehot;

`ifdef ARB_TIMEOUT_EN
    localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(TIMEOUT_CYCLES - 1);
    logic [CNT_W-1:0] hold_cnt;
`endif

    // Release/revoke detection and the scan start used this edge.
    always_comb begin
        holder_req  = req[gnt_idx];
        release_now = (state == GRANT) && !holder_req;
        revoke      = 1'b0;
`ifdef ARB_TIMEOUT_EN
        revoke      = (state == GRANT) && holder_req && (hold_cnt == HOLD_LAST);
`endif
        // On hand-off the scan starts just past the outgoing holder, which is
        // exactly the pointer value being committed on the same edge.
        scan_ptr    = (state == GRANT) ? gnt_idx + IDX_W'(1) : rr_ptr;
        pick        = rr_pick(req, scan_ptr);
    end

    // Next-state and next-grant decision.
    always_comb begin
        state_nxt = state;
        ptr_nxt   = rr_ptr;
        idx_nxt   = gnt_idx;
        vld_nxt   = gnt_valid;
        new_grant = 1'b0;
        case (state)
            IDLE: begin
                if (pick[IDX_W]) begin
                    state_nxt = GRANT;
                    idx_nxt   = pick[IDX_W-1:0];
                    vld_nxt   = 1'b1;
                    new_grant = 1'b1;
                end
            end
            GRANT: begin
                if (release_now || revoke) begin
                    ptr_nxt = scan_ptr;
                    if (pick[IDX_W]) begin
                        idx_nxt   = pick[IDX_W-1:0];
                        new_grant = 1'b1;
                    end else begin
                        state_nxt = IDLE;
                        vld_nxt   = 1'b0;
                    end
                end
            end
            default: begin
                state_nxt = IDLE;
                vld_nxt   = 1'b0;
            end
        endcase
    end

    onehot_dec_3to8 u_dec (
        .idx    (idx_nxt),
        .onehot (dec_onehot)
    );

    // State, pointer and registered grant outputs; reset drops gnt at once.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            rr_ptr    <= '0;
            gnt_idx   <= '0;
            gnt_valid <= 1'b0;
            gnt       <= '0;
        end else begin
            state     <= state_nxt;
            rr_ptr    <= ptr_nxt;
            gnt_idx   <= idx_nxt;
            gnt_valid <= vld_nxt;
            gnt       <= dec_onehot & {N_REQ{vld_nxt}};
        end
    end

`ifdef ARB_TIMEOUT_EN
    // Hold counter restarts on every fresh grant (including a re-grant after
    // revoke) and counts cycles spent by the current holder.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hold_cnt <= '0;
            timeout  <= 1'b0;
        end else begin
            timeout <= revoke;
            if (new_grant) begin
                hold_cnt <= '0;
            end else if (state == GRANT) begin
                hold_cnt <= hold_cnt + CNT_W'(1);
            end
        end
    end
`else
    // Watchdog not built: grants are unbounded.
    assign timeout = 1'b0;
`endif

endmodule
